// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared widths and the EX/WB payload layout used for storage and parity.
package cv32e40p_pkg;
  localparam int REGFILE_ADDR_W = 6;
  localparam int FT_SEL_MUX_W = 3;
  typedef struct packed {
    logic                      valid;
    logic                      we;
    logic [REGFILE_ADDR_W-1:0] waddr;
    logic                      load;
    logic [FT_SEL_MUX_W-1:0]   sel_mux;
  } ex_wb_payload_t;
  function automatic logic payload_parity(input ex_wb_payload_t p, input logic odd);
    return ^p ^ odd;
  endfunction
endpackage

// File: rtl/cv32e40p_ex_wb_pipeline_if.sv
// cv32e40p_ex_wb_pipeline_if: EX-side inputs and WB-side outputs of the EX/WB register.
interface cv32e40p_ex_wb_pipeline_if;
  import cv32e40p_pkg::*;
  logic                      ex_valid_i;
  logic                      wb_ready_i;
  logic                      regfile_we_ex_i;
  logic [REGFILE_ADDR_W-1:0] regfile_waddr_ex_i;
  logic                      data_req_ex_i;
  logic                      data_we_ex_i;
  logic [FT_SEL_MUX_W-1:0]   sel_mux_ex_i;
  logic                      wb_valid_o;
  logic                      regfile_we_wb_o;
  logic [REGFILE_ADDR_W-1:0] regfile_waddr_wb_o;
  logic                      load_in_wb_o;
  logic [FT_SEL_MUX_W-1:0]   sel_mux_wb_o;
  modport master (
    output ex_valid_i, wb_ready_i, regfile_we_ex_i, regfile_waddr_ex_i,
           data_req_ex_i, data_we_ex_i, sel_mux_ex_i,
    input  wb_valid_o, regfile_we_wb_o, regfile_waddr_wb_o, load_in_wb_o, sel_mux_wb_o
  );
  modport slave (
    input  ex_valid_i, wb_ready_i, regfile_we_ex_i, regfile_waddr_ex_i,
           data_req_ex_i, data_we_ex_i, sel_mux_ex_i,
    output wb_valid_o, regfile_we_wb_o, regfile_waddr_wb_o, load_in_wb_o, sel_mux_wb_o
  );
endinterface

// File: rtl/cv32e40p_ft_err_counter.sv
// cv32e40p_ft_err_counter: counts rising edges of an error flag, saturating, with sync clear.
module cv32e40p_ft_err_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);
  logic             err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear_i ? '0 : (err_i && !err_q && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_i;
      cnt_q <= cnt_d;
    end
  end
  assign count_o = cnt_q;
endmodule

// File: rtl/cv32e40p_ex_wb_pipeline.sv
// cv32e40p_ex_wb_pipeline: parity-protected EX/WB register with write masking and error counting.
module cv32e40p_ex_wb_pipeline
  import cv32e40p_pkg::*;
#(
  parameter bit PARITY_ODD  = 1'b0,
  parameter bit MASK_ON_ERR = 1'b1,
  parameter int ERR_CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cv32e40p_ex_wb_pipeline_if.slave  bus,
  input  logic                      flush_i,
  input  logic                      err_clear_i,
  input  logic                      fault_inject_i,
  output logic                      parity_err_o,
  output logic [ERR_CNT_W-1:0]      err_count_o
);
  ex_wb_payload_t payload_q, payload_d;
  logic           par_q, par_d, write;
  // Flush and bubble both kill the slot; only valid/we/load change, address and mux select hold.
  always_comb begin
    payload_d = payload_q;
    write = flush_i | bus.ex_valid_i | bus.wb_ready_i;
    if (bus.ex_valid_i && !flush_i) begin
      payload_d.valid   = 1'b1;
      payload_d.we      = bus.regfile_we_ex_i;
      payload_d.waddr   = bus.regfile_we_ex_i ? bus.regfile_waddr_ex_i : payload_q.waddr;
      payload_d.load    = bus.data_req_ex_i & ~bus.data_we_ex_i;
      payload_d.sel_mux = bus.sel_mux_ex_i;
    end else if (write) begin
      payload_d.valid = 1'b0;
      payload_d.we    = 1'b0;
      payload_d.load  = 1'b0;
    end
    par_d = payload_parity(payload_d, PARITY_ODD) ^ fault_inject_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_q <= '0;
      par_q     <= PARITY_ODD;
    end else if (write) begin
      payload_q <= payload_d;
      par_q     <= par_d;
    end
  end
  assign parity_err_o           = payload_parity(payload_q, PARITY_ODD) != par_q;
  assign bus.wb_valid_o         = payload_q.valid;
  assign bus.regfile_we_wb_o    = payload_q.we & ~(MASK_ON_ERR & parity_err_o);
  assign bus.regfile_waddr_wb_o = payload_q.waddr;
  assign bus.load_in_wb_o       = payload_q.load;
  assign bus.sel_mux_wb_o       = payload_q.sel_mux;
  cv32e40p_ft_err_counter #(.CNT_W(ERR_CNT_W)) u_err_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .err_i  (parity_err_o),
    .clear_i(err_clear_i),
    .count_o(err_count_o)
  );
endmodule
